// File: rtl/sram_cache_controller.sv
// 2-way set-associative, write-through, no-write-allocate cache sitting
// between the MEM stage and the SRAM controller. Read hits return data in
// the same cycle; a read miss fetches the 64-bit line as two 32-bit SRAM
// reads; every write is forwarded to SRAM and updates the line on a hit.
module sram_cache_controller #(
   parameter int SETS  = 64,
   parameter int TAG_W = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        read,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [31:0] dataIn,
   output logic [31:0] dataOut,
   output logic        freeze,
   output logic        sramRead,
   output logic        sramWrite,
   output logic [31:0] sramAddress,
   output logic [31:0] sramWriteData,
   input  logic [31:0] sramReadData,
   input  logic        sramFreeze
);

   localparam int IDX_W = $clog2(SETS);

   typedef enum logic [2:0] {IDLE, FILL0, FILL1, UPDATE, WRITE} state_t;

   state_t state_reg, state_next;

   // Request decode: [2] word select, [IDX_W+2:3] set index, tag above it.
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;
   assign idx = address[3 +: IDX_W];
   assign tag = address[3 + IDX_W +: TAG_W];

   // Byte-offset bits are irrelevant to a word-wide cache.
   logic unused_addr_bits;
   assign unused_addr_bits = ^address[1:0];

   // Line address of the fill in progress, captured when the miss is taken so
   // the second SRAM read and the install do not depend on the request bus.
   logic [28:0]      fill_line_reg;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   assign fill_idx = fill_line_reg[IDX_W-1:0];
   assign fill_tag = fill_line_reg[IDX_W +: TAG_W];

   logic [31:0] buf0_reg, buf1_reg;
   logic [SETS-1:0] lru_reg;

   logic [1:0]  hit;
   logic [1:0]  vict_valid;
   logic [1:0]  line_we;
   logic [1:0]  word_we;
   logic [31:0] rd_word [2];
   logic        hit_any;
   logic        hit_way;
   logic        victim;

   assign hit_any = |hit;
   assign hit_way = ~hit[0];

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_way
         logic [TAG_W-1:0] tag_mem   [SETS];
         logic [31:0]      word0_mem [SETS];
         logic [31:0]      word1_mem [SETS];
         logic [SETS-1:0]  valid_reg;

         // Valid bits: cleared by reset, set when a filled line is installed.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst)
               valid_reg <= '0;
            else if (line_we[gi])
               valid_reg[fill_idx] <= 1'b1;
         end

         // Tag/data storage: whole-line install on fill, single word on write hit.
         always_ff @(posedge clk) begin
            if (line_we[gi]) begin
               tag_mem[fill_idx]   <= fill_tag;
               word0_mem[fill_idx] <= buf0_reg;
               word1_mem[fill_idx] <= buf1_reg;
            end else if (word_we[gi]) begin
               if (address[2])
                  word1_mem[idx] <= dataIn;
               else
                  word0_mem[idx] <= dataIn;
            end
         end

         assign hit[gi]        = valid_reg[idx] & (tag_mem[idx] == tag);
         assign rd_word[gi]    = address[2] ? word1_mem[idx] : word0_mem[idx];
         assign vict_valid[gi] = valid_reg[fill_idx];
      end
   endgenerate

   // Victim choice and storage write enables.
   always_comb begin
      line_we = '0;
      word_we = '0;
      if (!vict_valid[0])
         victim = 1'b0;
      else if (!vict_valid[1])
         victim = 1'b1;
      else
         victim = lru_reg[fill_idx];
      if (state_reg == UPDATE)
         line_we[victim] = 1'b1;
      if (state_reg == IDLE && write && hit_any)
         word_we[hit_way] = 1'b1;
   end

   // LRU bits: after any touch, point at the way that was not touched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         lru_reg <= '0;
      else if (state_reg == IDLE && (read || write) && hit_any)
         lru_reg[idx] <= ~hit_way;
      else if (state_reg == UPDATE)
         lru_reg[fill_idx] <= ~victim;
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next state, freeze and read data.
   always_comb begin
      state_next = state_reg;
      freeze     = (read & ~hit_any & ~write) | write | (state_reg != IDLE);
      dataOut    = (read && hit_any) ? (hit[0] ? rd_word[0] : rd_word[1]) : 32'd0;
      case (state_reg)
         IDLE: begin
            if (write)
               state_next = WRITE;
            else if (read && !hit_any)
               state_next = FILL0;
         end
         FILL0:  if (!sramFreeze) state_next = FILL1;
         FILL1:  if (!sramFreeze) state_next = UPDATE;
         UPDATE: state_next = IDLE;
         WRITE: begin
            if (!sramFreeze) begin
               state_next = IDLE;
               freeze     = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // SRAM request registers and fill buffer, loaded on state transitions.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sramRead      <= 1'b0;
         sramWrite     <= 1'b0;
         sramAddress   <= '0;
         sramWriteData <= '0;
         buf0_reg      <= '0;
         buf1_reg      <= '0;
         fill_line_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (write) begin
                  sramWrite     <= 1'b1;
                  sramAddress   <= {address[31:2], 2'b00};
                  sramWriteData <= dataIn;
               end else if (read && !hit_any) begin
                  sramRead      <= 1'b1;
                  sramAddress   <= {address[31:3], 3'b000};
                  fill_line_reg <= address[31:3];
               end
            end
            FILL0: begin
               if (!sramFreeze) begin
                  buf0_reg    <= sramReadData;
                  sramAddress <= {fill_line_reg, 3'b100};
               end
            end
            FILL1: begin
               if (!sramFreeze) begin
                  buf1_reg <= sramReadData;
                  sramRead <= 1'b0;
               end
            end
            WRITE: begin
               if (!sramFreeze)
                  sramWrite <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_cache_controller.sv
// Bench for sram_cache_controller: a behavioural SRAM with programmable
// wait states, a recency-list model of cache residency, one per-cycle
// compare process and directed read/write transactions.
module tb_sram_cache_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        read = 1'b0;
   logic        write = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] dataIn = '0;
   logic [31:0] dataOut;
   logic        freeze;
   logic        sramRead;
   logic        sramWrite;
   logic [31:0] sramAddress;
   logic [31:0] sramWriteData;
   logic [31:0] sramReadData = '0;
   logic        sramFreeze = 1'b0;

   int errors = 0;
   int checks = 0;
   bit started = 0;
   int lat = 0;

   sram_cache_controller dut (
      .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
      .dataIn(dataIn), .dataOut(dataOut), .freeze(freeze),
      .sramRead(sramRead), .sramWrite(sramWrite), .sramAddress(sramAddress),
      .sramWriteData(sramWriteData), .sramReadData(sramReadData),
      .sramFreeze(sramFreeze)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // ---------------- SRAM model ----------------
   typedef struct { bit we; logic [31:0] addr; logic [31:0] data; } txn_t;
   txn_t txns[$];
   logic [31:0] mem [int unsigned];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   int   busy = 0;
   bit   pend = 0;
   txn_t pend_t;

   always @(negedge clk) begin
      if (!rst) begin
         pend = 0;
         sramFreeze = 1'b0;
         busy = lat;
      end else begin
         if (pend) begin
            txns.push_back(pend_t);
            if (pend_t.we) mem[pend_t.addr] = pend_t.data;
            busy = lat;
            pend = 0;
         end
         if (sramRead || sramWrite) begin
            if (busy > 0) begin
               sramFreeze = 1'b1;
               busy--;
            end else begin
               sramFreeze = 1'b0;
               pend = 1;
               pend_t.we = sramWrite;
               pend_t.addr = sramAddress;
               pend_t.data = sramWriteData;
               sramReadData = mem_rd(sramAddress);
            end
         end else begin
            sramFreeze = 1'b0;
            busy = lat;
         end
      end
   end

   // ---------------- cache residency model ----------------
   // Lines ordered from least to most recently used; at most two per set.
   int unsigned lines[$];

   function automatic bit model_has(input int unsigned line);
      foreach (lines[i]) if (lines[i] == line) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_touch(input int unsigned line);
      for (int i = 0; i < lines.size(); i++)
         if (lines[i] == line) begin
            lines.delete(i);
            break;
         end
      lines.push_back(line);
   endtask

   task automatic model_install(input int unsigned line);
      int cnt = 0;
      int first = -1;
      foreach (lines[i])
         if (lines[i] % 64 == line % 64) begin
            if (first < 0) first = i;
            cnt++;
         end
      if (cnt >= 2) lines.delete(first);
      lines.push_back(line);
   endtask

   // ---------------- per-cycle compare ----------------
   always begin
      @(negedge clk);
      #2;
      if (started) begin
         check("rd_wr_exclusive", {31'd0, sramRead & sramWrite}, 32'd0);
         if (read && !write && !freeze)
            check("dataout_vs_mem", dataOut, mem_rd({address[31:2], 2'b00}));
         if (!read && !write) begin
            check("idle_freeze", {31'd0, freeze}, 32'd0);
            check("idle_dataout", dataOut, 32'd0);
         end
      end
   end

   // ---------------- transactions ----------------
   task automatic do_read(input logic [31:0] a, input int l, input int hand_hit,
                          input bit chk_data, input logic [31:0] hand_data);
      int unsigned line;
      bit exp_hit, done;
      int n;
      logic [31:0] got;
      lat = l;
      txns.delete();
      line = a >> 3;
      exp_hit = model_has(line);
      @(posedge clk); #1;
      address = a;
      read = 1'b1;
      n = 0; done = 0; got = '0;
      while (!done && n < 200) begin
         @(negedge clk); #2;
         if (freeze) n++;
         else begin
            done = 1;
            got = dataOut;
         end
      end
      if (!done) check("read_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      read = 1'b0;
      @(negedge clk); #2;
      check("read_stall", n, exp_hit ? 0 : 2 * l + 4);
      if (exp_hit) check("read_txn_count", txns.size(), 0);
      else begin
         check("read_txn_count", txns.size(), 2);
         if (txns.size() == 2) begin
            check("fill0_addr", txns[0].addr, line << 3);
            check("fill1_addr", txns[1].addr, (line << 3) + 4);
            check("fill_is_read", {30'd0, txns[0].we, txns[1].we}, 32'd0);
         end
      end
      if (hand_hit >= 0) check("read_hit_hand", {31'd0, n == 0}, hand_hit);
      if (chk_data) check("read_data_hand", got, hand_data);
      if (exp_hit) model_touch(line);
      else model_install(line);
      $display("read  addr=%h data=%h %s stall=%0d", a, got, (n == 0) ? "hit " : "miss", n);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int l);
      int unsigned line;
      bit done;
      int n;
      lat = l;
      txns.delete();
      line = a >> 3;
      @(posedge clk); #1;
      address = a;
      dataIn = d;
      write = 1'b1;
      n = 0; done = 0;
      while (!done && n < 200) begin
         @(negedge clk); #2;
         if (freeze) n++;
         else done = 1;
      end
      if (!done) check("write_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      write = 1'b0;
      @(negedge clk); #2;
      check("write_stall", n, l + 1);
      check("write_txn_count", txns.size(), 1);
      if (txns.size() == 1) begin
         check("write_is_write", {31'd0, txns[0].we}, 32'd1);
         check("write_addr", txns[0].addr, {a[31:2], 2'b00});
         check("write_data", txns[0].data, d);
      end
      if (model_has(line)) model_touch(line);
      $display("write addr=%h data=%h %s stall=%0d", a, d, model_has(line) ? "hit " : "miss", n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit found;
      mem[32'h0000_1000] = 32'h1234_5678;
      mem[32'h0000_1004] = 32'hCAFE_0001;

      // Reset state
      #3 rst = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check("rst_freeze", {31'd0, freeze}, 32'd0);
      check("rst_dataout", dataOut, 32'd0);
      check("rst_sramread", {31'd0, sramRead}, 32'd0);
      check("rst_sramwrite", {31'd0, sramWrite}, 32'd0);
      check("rst_sramaddr", sramAddress, 32'd0);
      check("rst_sramwdata", sramWriteData, 32'd0);
      #1 rst = 1'b1;
      started = 1;

      // Cold miss, then hit on the other word of the line
      do_read(32'h0000_1000, 2, 0, 1, 32'h1234_5678);
      do_read(32'h0000_1004, 1, 1, 1, 32'hCAFE_0001);

      // LRU replacement within set 0: A, B, A, C (evicts B), A, B
      do_read(32'h0000_1200, 1, 0, 0, 32'd0);
      do_read(32'h0000_1000, 1, 1, 0, 32'd0);
      do_read(32'h0000_1400, 0, 0, 0, 32'd0);
      do_read(32'h0000_1000, 1, 1, 0, 32'd0);
      do_read(32'h0000_1200, 1, 0, 0, 32'd0);

      // Write hit updates the cached word; write miss does not allocate
      do_write(32'h0000_1000, 32'hDEAD_BEEF, 1);
      do_read(32'h0000_1000, 1, 1, 1, 32'hDEAD_BEEF);
      do_write(32'h0000_3000, 32'h0BAD_F00D, 0);
      do_read(32'h0000_3000, 1, 0, 1, 32'h0BAD_F00D);
      do_write(32'h0000_1404, 32'h5555_AAAA, 3);
      do_read(32'h0000_1404, 0, 0, 1, 32'h5555_AAAA);

      // Reset while the second fill read is pending
      lat = 4;
      txns.delete();
      @(posedge clk); #1;
      address = 32'h0000_5008;
      read = 1'b1;
      n = 0; found = 0;
      while (!found && n < 100) begin
         @(negedge clk); #2;
         n++;
         if (sramRead && sramAddress == 32'h0000_500C && sramFreeze) found = 1;
      end
      check("fill1_reached", {31'd0, found}, 32'd1);
      #1;
      rst = 1'b0;
      read = 1'b0;
      #1;
      check("midfill_rst_sramread", {31'd0, sramRead}, 32'd0);
      check("midfill_rst_sramaddr", sramAddress, 32'd0);
      check("midfill_rst_freeze", {31'd0, freeze}, 32'd0);
      $display("reset during fill addr=%h", 32'h0000_5008);
      lines.delete();
      repeat (2) @(negedge clk);
      #3 rst = 1'b1;
      do_read(32'h0000_1000, 1, 0, 1, 32'hDEAD_BEEF);
      do_read(32'h0000_5008, 1, 0, 0, 32'd0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
